qdma_channel_scheduler: RTL and testbench

- Multi-channel front end for the single QDMA byte-transfer engine.
- Arbitrates up to NUM_CH requesting channels round-robin and runs the CPU bus-hold handshake (hrq/hlda) once per granted channel.
- Splits each channel's burst into single-byte engine commands (eng_start/eng_done), increments addresses and reports per-channel completion or timeout.

---
 rtl/qdma_channel_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_qdma_channel_scheduler.sv | 612 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdma_channel_scheduler.sv
// qdma_channel_scheduler: round-robin front end for the single QDMA byte engine.
// Holds the CPU bus per granted channel and feeds the engine one byte at a time.
module qdma_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     drq,
  input  logic [2*NUM_CH-1:0]   ch_type,
  input  logic [3*NUM_CH-1:0]   ch_src_module,
  input  logic [3*NUM_CH-1:0]   ch_dest_module,
  input  logic [5*NUM_CH-1:0]   ch_src_addr,
  input  logic [5*NUM_CH-1:0]   ch_dest_addr,
  input  logic [LEN_W*NUM_CH-1:0] ch_len,
  output logic                  hrq,
  input  logic                  hlda,
  output logic [NUM_CH-1:0]     dack,
  output logic [NUM_CH-1:0]     ch_done,
  output logic [NUM_CH-1:0]     ch_err,
  output logic                  eng_start,
  output logic [1:0]            eng_type,
  output logic [2:0]            eng_src_module,
  output logic [2:0]            eng_dest_module,
  output logic [4:0]            eng_src_addr,
  output logic [4:0]            eng_dest_addr,
  input  logic                  eng_done,
  output logic                  busy,
  output logic [2:0]            grant_id
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, HOLD, ISSUE, WAIT, RELEASE
  } state_t;

  state_t state, state_d;

  logic [2:0]        last_grant, last_d;
  logic [2:0]        gid_d, pick;
  logic [TMR_W-1:0]  timer, timer_d;
  logic [LEN_W-1:0]  beats_left, beats_d;
  logic              hrq_d, busy_d, start_d;
  logic [NUM_CH-1:0] dack_d, done_d, err_d;
  logic [NUM_CH-1:0] grant_oh;
  logic [1:0]        type_d, sel_type;
  logic [2:0]        smod_d, dmod_d;
  logic [2:0]        sel_smod, sel_dmod;
  logic [4:0]        src_d, dst_d;
  logic [4:0]        sel_src, sel_dst;
  logic [LEN_W-1:0]  sel_len;

  // Lowest requester above last_grant wins; otherwise lowest overall.
  always_comb begin
    pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (drq[i]) pick = 3'(i);
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (drq[i] && i > int'(last_grant)) pick = 3'(i);
  end

  always_comb begin
    sel_type = '0;
    sel_smod = '0;
    sel_dmod = '0;
    sel_src  = '0;
    sel_dst  = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (pick == 3'(i)) begin
        sel_type = ch_type[2*i +: 2];
        sel_smod = ch_src_module[3*i +: 3];
        sel_dmod = ch_dest_module[3*i +: 3];
        sel_src  = ch_src_addr[5*i +: 5];
        sel_dst  = ch_dest_addr[5*i +: 5];
        sel_len  = ch_len[LEN_W*i +: LEN_W];
      end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_CH; i++)
      grant_oh[i] = (grant_id == 3'(i));
  end

  always_comb begin
    state_d = state;
    hrq_d   = hrq;
    dack_d  = dack;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    busy_d  = busy;
    gid_d   = grant_id;
    last_d  = last_grant;
    timer_d = timer;
    beats_d = beats_left;
    type_d  = eng_type;
    smod_d  = eng_src_module;
    dmod_d  = eng_dest_module;
    src_d   = eng_src_addr;
    dst_d   = eng_dest_addr;
    unique case (state)
      IDLE: begin
        if (|drq) begin
          state_d = HOLD;
          hrq_d   = 1'b1;
          busy_d  = 1'b1;
          gid_d   = pick;
          type_d  = sel_type;
          smod_d  = sel_smod;
          dmod_d  = sel_dmod;
          src_d   = sel_src;
          dst_d   = sel_dst;
          beats_d = sel_len;
        end
      end
      HOLD: begin
        if (hlda) begin
          state_d = ISSUE;
          dack_d  = grant_oh;
        end
      end
      ISSUE: begin
        if (hlda) begin
          state_d = WAIT;
          start_d = 1'b1;
          timer_d = '0;
        end else begin
          state_d = HOLD;
          dack_d  = '0;
        end
      end
      WAIT: begin
        timer_d = timer + TMR_W'(1);
        if (eng_done && beats_left != '0) begin
          state_d = ISSUE;
          src_d   = eng_src_addr + 5'd1;
          dst_d   = eng_dest_addr + 5'd1;
          beats_d = beats_left - LEN_W'(1);
        end else if (eng_done || timer == TMR_W'(TIMEOUT)) begin
          // A late eng_done on the timeout cycle still counts as success.
          state_d = RELEASE;
          hrq_d   = 1'b0;
          dack_d  = '0;
          last_d  = grant_id;
          if (eng_done) done_d = grant_oh;
          else          err_d  = grant_oh;
        end
      end
      RELEASE: begin
        hrq_d  = 1'b0;
        dack_d = '0;
        if (!hlda) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      hrq             <= 1'b0;
      dack            <= '0;
      ch_done         <= '0;
      ch_err          <= '0;
      eng_start       <= 1'b0;
      busy            <= 1'b0;
      grant_id        <= '0;
      last_grant      <= 3'(NUM_CH - 1);
      timer           <= '0;
      beats_left      <= '0;
      eng_type        <= '0;
      eng_src_module  <= '0;
      eng_dest_module <= '0;
      eng_src_addr    <= '0;
      eng_dest_addr   <= '0;
    end else begin
      state           <= state_d;
      hrq             <= hrq_d;
      dack            <= dack_d;
      ch_done         <= done_d;
      ch_err          <= err_d;
      eng_start       <= start_d;
      busy            <= busy_d;
      grant_id        <= gid_d;
      last_grant      <= last_d;
      timer           <= timer_d;
      beats_left      <= beats_d;
      eng_type        <= type_d;
      eng_src_module  <= smod_d;
      eng_dest_module <= dmod_d;
      eng_src_addr    <= src_d;
      eng_dest_addr   <= dst_d;
    end
  end

endmodule

// File: tb/tb_qdma_channel_scheduler.sv
// tb_qdma_channel_scheduler: randomized bench with a CPU/engine responder
// and a transaction-level round-robin reference model.
module tb_qdma_channel_scheduler;

  localparam int NUM_CH  = 4;
  localparam int LEN_W   = 5;
  localparam int TIMEOUT = 15;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       drq;
  logic [2*NUM_CH-1:0]     ch_type;
  logic [3*NUM_CH-1:0]     ch_src_module;
  logic [3*NUM_CH-1:0]     ch_dest_module;
  logic [5*NUM_CH-1:0]     ch_src_addr;
  logic [5*NUM_CH-1:0]     ch_dest_addr;
  logic [LEN_W*NUM_CH-1:0] ch_len;
  logic                    hrq;
  logic                    hlda;
  logic [NUM_CH-1:0]       dack;
  logic [NUM_CH-1:0]       ch_done;
  logic [NUM_CH-1:0]       ch_err;
  logic                    eng_start;
  logic [1:0]              eng_type;
  logic [2:0]              eng_src_module;
  logic [2:0]              eng_dest_module;
  logic [4:0]              eng_src_addr;
  logic [4:0]              eng_dest_addr;
  logic                    eng_done;
  logic                    busy;
  logic [2:0]              grant_id;

  qdma_channel_scheduler #(
    .NUM_CH(NUM_CH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .drq(drq),
    .ch_type(ch_type),
    .ch_src_module(ch_src_module),
    .ch_dest_module(ch_dest_module),
    .ch_src_addr(ch_src_addr),
    .ch_dest_addr(ch_dest_addr),
    .ch_len(ch_len),
    .hrq(hrq), .hlda(hlda), .dack(dack),
    .ch_done(ch_done), .ch_err(ch_err),
    .eng_start(eng_start), .eng_type(eng_type),
    .eng_src_module(eng_src_module),
    .eng_dest_module(eng_dest_module),
    .eng_src_addr(eng_src_addr),
    .eng_dest_addr(eng_dest_addr),
    .eng_done(eng_done), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                gid;
    logic [NUM_CH-1:0] dack;
    logic [4:0]        src;
    logic [4:0]        dst;
    logic [1:0]        typ;
    logic [2:0]        sm;
    logic [2:0]        dm;
    int                cyc;
  } start_t;

  typedef struct {
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] err;
    int                cyc;
  } comp_t;

  start_t starts[$];
  comp_t  comps[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_last;
  int eng_lat = 3;
  int pend = 0;
  bit eng_mute = 1'b0;
  bit cpu_block = 1'b0;
  logic [1:0] hp = 2'b00;

  logic [1:0]       c_type[NUM_CH];
  logic [2:0]       c_sm[NUM_CH];
  logic [2:0]       c_dm[NUM_CH];
  logic [4:0]       c_src[NUM_CH];
  logic [4:0]       c_dst[NUM_CH];
  logic [LEN_W-1:0] c_len[NUM_CH];

  // Monitor: log every engine command and completion pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (eng_start) begin
        start_t s;
        s.gid  = int'(grant_id);
        s.dack = dack;
        s.src  = eng_src_addr;
        s.dst  = eng_dest_addr;
        s.typ  = eng_type;
        s.sm   = eng_src_module;
        s.dm   = eng_dest_module;
        s.cyc  = cyc;
        starts.push_back(s);
      end
      if (|ch_done || |ch_err) begin
        comp_t c;
        c.done = ch_done;
        c.err  = ch_err;
        c.cyc  = cyc;
        comps.push_back(c);
      end
    end
  end

  // CPU: grants the hold two cycles after hrq, unless blocked.
  initial begin
    hlda = 1'b0;
    forever begin
      @(negedge clk);
      hp = {hp[0], hrq};
      hlda = cpu_block ? 1'b0 : hp[1];
    end
  end

  // Engine: answers each start after eng_lat cycles.
  initial begin
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!rst) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) eng_done = 1'b1;
      end
      if (rst && eng_start && !eng_mute) pend = eng_lat;
    end
  end

  function automatic int next_grant(input int last,
                                    input logic [NUM_CH-1:0] mask);
    for (int k = 1; k <= NUM_CH; k++)
      if (mask[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  task automatic apply_cfg;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_type[2*i +: 2]         = c_type[i];
      ch_src_module[3*i +: 3]   = c_sm[i];
      ch_dest_module[3*i +: 3]  = c_dm[i];
      ch_src_addr[5*i +: 5]     = c_src[i];
      ch_dest_addr[5*i +: 5]    = c_dst[i];
      ch_len[LEN_W*i +: LEN_W]  = c_len[i];
    end
  endtask

  task automatic rand_cfg(input int maxlen);
    for (int i = 0; i < NUM_CH; i++) begin
      c_type[i] = 2'($urandom_range(0, 1));
      c_sm[i]   = 3'($urandom);
      c_dm[i]   = 3'($urandom);
      c_src[i]  = 5'($urandom);
      c_dst[i]  = 5'($urandom);
      c_len[i]  = LEN_W'($urandom_range(0, maxlen));
    end
    apply_cfg();
  endtask

  task automatic wait_comps(input int n, input int budget,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (comps.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (!busy && !hlda && hp == 2'b00) ok = 1'b1;
    end
  endtask

  task automatic run_bursts(input logic [NUM_CH-1:0] mask,
                            input int n, output bit ok);
    bit ok2;
    starts.delete();
    comps.delete();
    @(negedge clk); #1;
    drq = mask;
    wait_comps(n, 300 * n, ok);
    drq = '0;
    wait_idle(ok2);
    ok = ok & ok2;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drq = '0;
    rand_cfg(3);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({hrq, busy, eng_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000",
               {hrq, busy, eng_start});
    end
    checks++;
    if (dack !== '0) begin
      errors++;
      $display("FAIL reset_dack: got %b want 0", dack);
    end
    checks++;
    if ((ch_done | ch_err) !== '0) begin
      errors++;
      $display("FAIL reset_pulse: got %b/%b want 0", ch_done, ch_err);
    end
    checks++;
    if ({grant_id, eng_type, eng_src_module, eng_dest_module,
         eng_src_addr, eng_dest_addr} !== '0) begin
      errors++;
      $display("FAIL reset_bus: gid %0d src %0d dst %0d want 0",
               grant_id, eng_src_addr, eng_dest_addr);
    end
    rst = 1'b1;
    m_last = NUM_CH - 1;
  endtask

  task automatic test_single;
    bit ok;
    rand_cfg(3);
    c_src[0] = 5'd3;
    c_dst[0] = 5'd10;
    c_len[0] = LEN_W'(2);
    c_type[0] = 2'b01;
    apply_cfg();
    eng_lat = 3;
    starts.delete();
    comps.delete();
    @(negedge clk); #1;
    drq = 4'b0001;
    @(negedge clk); #1;
    checks++;
    if ({hrq, busy, grant_id} !== {2'b11, 3'd0}) begin
      errors++;
      $display("FAIL single_arb: hrq %b busy %b gid %0d want 1 1 0",
               hrq, busy, grant_id);
    end
    drq = '0;
    wait_comps(1, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_wait: no completion, want ch_done 0001");
    end
    wait_idle(ok);
    checks++;
    if (starts.size() != 3) begin
      errors++;
      $display("FAIL single_count: got %0d starts want 3",
               starts.size());
    end
    for (int j = 0; j < 3 && j < starts.size(); j++) begin
      checks++;
      if (starts[j].src !== 5'(3 + j) || starts[j].dst !== 5'(10 + j) ||
          starts[j].gid != 0 || starts[j].dack !== 4'b0001 ||
          starts[j].typ !== 2'b01 || starts[j].sm !== c_sm[0] ||
          starts[j].dm !== c_dm[0]) begin
        errors++;
        $display("FAIL single_beat%0d: src %0d dst %0d gid %0d dack %b want %0d %0d 0 0001",
                 j, starts[j].src, starts[j].dst, starts[j].gid,
                 starts[j].dack, 3 + j, 10 + j);
      end
      if (j > 0) begin
        checks++;
        if (starts[j].cyc - starts[j-1].cyc < 2) begin
          errors++;
          $display("FAIL single_pace: gap %0d want >=2",
                   starts[j].cyc - starts[j-1].cyc);
        end
      end
    end
    checks++;
    if (comps.size() != 1 || comps[0].done !== 4'b0001 ||
        comps[0].err !== 4'b0000) begin
      errors++;
      $display("FAIL single_done: n %0d done %b err %b want 1 0001 0000",
               comps.size(), comps.size() ? comps[0].done : 4'hx,
               comps.size() ? comps[0].err : 4'hx);
    end
    checks++;
    if (hrq !== 1'b0 || !ok) begin
      errors++;
      $display("FAIL single_hrq: hrq %b idle %b want 0 1", hrq, ok);
    end
    m_last = 0;
  endtask

  task automatic test_round_robin;
    bit ok;
    int g;
    logic [NUM_CH-1:0] oh;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    m_last = NUM_CH - 1;
    rand_cfg(0);
    eng_lat = $urandom_range(1, 4);
    run_bursts(4'b1111, 5, ok);
    checks++;
    if (!ok || starts.size() != 5 || comps.size() != 5) begin
      errors++;
      $display("FAIL rr_count: ok %b starts %0d comps %0d want 1 5 5",
               ok, starts.size(), comps.size());
    end
    g = m_last;
    for (int k = 0; k < 5 && k < starts.size() && k < comps.size(); k++) begin
      g = next_grant(g, 4'b1111);
      oh = '0;
      oh[g] = 1'b1;
      checks++;
      if (starts[k].gid != g || starts[k].dack !== oh ||
          comps[k].done !== oh) begin
        errors++;
        $display("FAIL rr_grant%0d: gid %0d dack %b done %b want %0d %b",
                 k, starts[k].gid, starts[k].dack, comps[k].done, g, oh);
      end
    end
    m_last = g;
  endtask

  task automatic test_random_bursts;
    bit ok;
    int g, idx, n, tot;
    logic [NUM_CH-1:0] mask, oh;
    logic [4:0] es, ed;
    for (int it = 0; it < 6; it++) begin
      rand_cfg(5);
      eng_lat = $urandom_range(1, 4);
      mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      n = $urandom_range(1, 4);
      run_bursts(mask, n, ok);
      idx = 0;
      tot = 0;
      g = m_last;
      for (int k = 0; k < n; k++) begin
        g = next_grant(g, mask);
        oh = '0;
        oh[g] = 1'b1;
        for (int j = 0; j <= int'(c_len[g]); j++) begin
          es = 5'((int'(c_src[g]) + j) % 32);
          ed = 5'((int'(c_dst[g]) + j) % 32);
          tot++;
          if (idx < starts.size()) begin
            checks++;
            if (starts[idx].gid != g || starts[idx].dack !== oh ||
                starts[idx].src !== es || starts[idx].dst !== ed ||
                starts[idx].typ !== c_type[g] ||
                starts[idx].sm !== c_sm[g] ||
                starts[idx].dm !== c_dm[g]) begin
              errors++;
              $display("FAIL rand_beat%0d_%0d: ch %0d src %0d dst %0d want ch %0d src %0d dst %0d",
                       it, idx, starts[idx].gid, starts[idx].src,
                       starts[idx].dst, g, es, ed);
            end
          end
          idx++;
        end
        if (k < comps.size()) begin
          checks++;
          if (comps[k].done !== oh || comps[k].err !== '0) begin
            errors++;
            $display("FAIL rand_done%0d_%0d: done %b err %b want %b 0",
                     it, k, comps[k].done, comps[k].err, oh);
          end
        end
      end
      checks++;
      if (!ok || starts.size() != tot || comps.size() != n) begin
        errors++;
        $display("FAIL rand_count%0d: ok %b starts %0d comps %0d want 1 %0d %0d",
                 it, ok, starts.size(), comps.size(), tot, n);
      end
      m_last = g;
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int c;
    rand_cfg(2);
    c = $urandom_range(0, NUM_CH - 1);
    c_src[c] = 5'd30;
    c_dst[c] = 5'd31;
    c_len[c] = LEN_W'(3);
    apply_cfg();
    eng_lat = 2;
    run_bursts(NUM_CH'(1) << c, 1, ok);
    checks++;
    if (!ok || starts.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: ok %b starts %0d want 1 4",
               ok, starts.size());
    end
    for (int j = 0; j < 4 && j < starts.size(); j++) begin
      checks++;
      if (starts[j].src !== 5'((30 + j) % 32) ||
          starts[j].dst !== 5'((31 + j) % 32)) begin
        errors++;
        $display("FAIL wrap_beat%0d: src %0d dst %0d want %0d %0d",
                 j, starts[j].src, starts[j].dst,
                 (30 + j) % 32, (31 + j) % 32);
      end
    end
    m_last = c;
  endtask

  task automatic test_timeout;
    bit ok;
    int c;
    logic [NUM_CH-1:0] oh;
    rand_cfg(5);
    c = $urandom_range(0, NUM_CH - 1);
    c_len[c] = LEN_W'($urandom_range(1, 5));
    apply_cfg();
    oh = '0;
    oh[c] = 1'b1;
    eng_mute = 1'b1;
    run_bursts(oh, 1, ok);
    eng_mute = 1'b0;
    checks++;
    if (!ok || starts.size() != 1 || comps.size() != 1) begin
      errors++;
      $display("FAIL tmo_count: ok %b starts %0d comps %0d want 1 1 1",
               ok, starts.size(), comps.size());
    end
    if (starts.size() == 1 && comps.size() == 1) begin
      checks++;
      if (comps[0].err !== oh || comps[0].done !== '0) begin
        errors++;
        $display("FAIL tmo_err: err %b done %b want %b 0",
                 comps[0].err, comps[0].done, oh);
      end
      checks++;
      if (comps[0].cyc - starts[0].cyc != TIMEOUT + 1) begin
        errors++;
        $display("FAIL tmo_delay: got %0d cycles want %0d",
                 comps[0].cyc - starts[0].cyc, TIMEOUT + 1);
      end
    end
    checks++;
    if (hrq !== 1'b0) begin
      errors++;
      $display("FAIL tmo_hrq: got %b want 0", hrq);
    end
    m_last = c;
  endtask

  task automatic test_hold_revoke;
    bit ok;
    int c;
    logic [NUM_CH-1:0] oh;
    rand_cfg(3);
    c = $urandom_range(0, NUM_CH - 1);
    c_len[c] = LEN_W'(2);
    apply_cfg();
    oh = '0;
    oh[c] = 1'b1;
    eng_lat = 3;
    starts.delete();
    comps.delete();
    @(negedge clk); #1;
    drq = oh;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (starts.size() >= 1) ok = 1'b1;
    end
    drq = '0;
    cpu_block = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL revoke_first: no start seen want 1");
    end
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (starts.size() != 1 || dack !== '0 || hrq !== 1'b1 ||
        busy !== 1'b1) begin
      errors++;
      $display("FAIL revoke_hold: starts %0d dack %b hrq %b busy %b want 1 0 1 1",
               starts.size(), dack, hrq, busy);
    end
    cpu_block = 1'b0;
    wait_comps(1, 300, ok);
    wait_idle(ok);
    checks++;
    if (starts.size() != 3 || comps.size() != 1) begin
      errors++;
      $display("FAIL revoke_count: starts %0d comps %0d want 3 1",
               starts.size(), comps.size());
    end
    for (int j = 0; j < 3 && j < starts.size(); j++) begin
      checks++;
      if (starts[j].src !== 5'((int'(c_src[c]) + j) % 32) ||
          starts[j].dst !== 5'((int'(c_dst[c]) + j) % 32) ||
          starts[j].dack !== oh) begin
        errors++;
        $display("FAIL revoke_beat%0d: src %0d dst %0d dack %b want %0d %0d %b",
                 j, starts[j].src, starts[j].dst, starts[j].dack,
                 (int'(c_src[c]) + j) % 32, (int'(c_dst[c]) + j) % 32, oh);
      end
    end
    if (comps.size() == 1) begin
      checks++;
      if (comps[0].done !== oh || comps[0].err !== '0) begin
        errors++;
        $display("FAIL revoke_done: done %b err %b want %b 0",
                 comps[0].done, comps[0].err, oh);
      end
    end
    m_last = c;
  endtask

  task automatic test_async_reset;
    bit ok;
    int c, s0;
    logic [NUM_CH-1:0] mask;
    rand_cfg(3);
    c = $urandom_range(1, NUM_CH - 1);
    c_len[c] = LEN_W'(7);
    apply_cfg();
    eng_lat = 4;
    starts.delete();
    comps.delete();
    @(negedge clk); #1;
    drq = NUM_CH'(1) << c;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (starts.size() >= 2) ok = 1'b1;
    end
    drq = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (!ok || {hrq, busy, eng_start} !== 3'b000 || dack !== '0) begin
      errors++;
      $display("FAIL areset_now: ok %b hrq %b busy %b dack %b want 1 0 0 0",
               ok, hrq, busy, dack);
    end
    s0 = starts.size();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (starts.size() != s0 || comps.size() != 0) begin
      errors++;
      $display("FAIL areset_quiet: starts %0d comps %0d want %0d 0",
               starts.size(), comps.size(), s0);
    end
    rst = 1'b1;
    m_last = NUM_CH - 1;
    mask = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1)) | 1;
    run_bursts(mask, 1, ok);
    checks++;
    if (!ok || starts.size() < 1 || starts[0].gid != 0 ||
        comps.size() != 1 || comps[0].done !== 4'b0001) begin
      errors++;
      $display("FAIL areset_first: ok %b gid %0d comps %0d want 1 0 1",
               ok, starts.size() ? starts[0].gid : -1, comps.size());
    end
    m_last = 0;
  endtask

  initial begin
    rst = 1'b0;
    drq = '0;
    ch_type = '0;
    ch_src_module = '0;
    ch_dest_module = '0;
    ch_src_addr = '0;
    ch_dest_addr = '0;
    ch_len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_random_bursts();
    test_wrap();
    test_timeout();
    test_hold_revoke();
    test_async_reset();
    test_random_bursts();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
